// File: rtl/elliot_derivative.sv
// Elliot activation derivative f'(x) = 1/(1+|x|>>SLOPE)^2, Q.FRAC fixed point.
// Ports: clk, reset (async high), start, x[31:0] in; busy, y[31:0], end_signal out.
module elliot_derivative #(
  parameter int FRAC  = 16,
  parameter int SLOPE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic [31:0] y,
  output logic        end_signal
);

  localparam int W2 = 2 * FRAC + 1;
  localparam int CW = $clog2(W2 + 1);
  localparam logic [32:0] ONE = 33'(1) << FRAC;

  typedef enum logic [1:0] {
    IDLE,
    SQ,
    DIV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [32:0]   den;
  logic [31:0]   den_sq;
  logic [32:0]   rem;
  logic [W2-1:0] dvd;
  logic [W2-1:0] quo;
  logic [CW-1:0] cnt;

  logic [31:0]   mag;
  logic [31:0]   a;
  logic [65:0]   prod;
  logic          sq_ovf;
  logic [31:0]   sq_val;
  logic [32:0]   rem_sh;
  logic          ge;
  logic [32:0]   rem_nx;
  logic [W2-1:0] quo_nx;
  logic          last;

  // 0x80000000 negates to itself, which is the wanted unsigned magnitude
  assign mag    = x[31] ? (~x + 32'd1) : x;
  assign a      = mag >> SLOPE;
  assign prod   = 66'(den) * 66'(den);
  assign sq_ovf = |prod[65:FRAC+32];
  assign sq_val = prod[FRAC+31:FRAC];

  // restoring step: shift in next dividend bit, subtract if it fits
  assign rem_sh = {rem[31:0], dvd[W2-1]};
  assign ge     = rem_sh >= {1'b0, den_sq};
  assign rem_nx = ge ? rem_sh - {1'b0, den_sq} : rem_sh;
  assign quo_nx = {quo[W2-2:0], ge};
  assign last   = cnt == CW'(W2 - 1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SQ;
      SQ:   state_nx = DIV;
      DIV:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      den        <= '0;
      den_sq     <= '0;
      rem        <= '0;
      dvd        <= '0;
      quo        <= '0;
      cnt        <= '0;
      y          <= '0;
      busy       <= 1'b0;
      end_signal <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            den  <= ONE + {1'b0, a};
            busy <= 1'b1;
          end
        end
        SQ: begin
          den_sq <= sq_ovf ? 32'hFFFF_FFFF : sq_val;
          rem    <= '0;
          dvd    <= W2'(1) << (2 * FRAC);
          quo    <= '0;
          cnt    <= '0;
        end
        DIV: begin
          rem <= rem_nx;
          dvd <= dvd << 1;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            y          <= 32'(quo_nx);
            end_signal <= 1'b1;
          end
        end
        DONE: begin
          end_signal <= 1'b0;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elliot_derivative.sv
// Directed bench for elliot_derivative: latency, values, saturation,
// held start, async reset abort, SLOPE=2 instance.
module tb_elliot_derivative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] x;
  logic        busy, end_signal;
  logic [31:0] y;
  logic        busy2, end2;
  logic [31:0] y2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elliot_derivative #(.FRAC(16), .SLOPE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .busy(busy), .y(y), .end_signal(end_signal)
  );

  elliot_derivative #(.FRAC(16), .SLOPE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .busy(busy2), .y(y2), .end_signal(end2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 1/(1+a)^2 via 2^32 / sat(((ONE+a)^2) >> 16)
  function automatic logic [31:0] ref_y(input logic [31:0] xv, input int s);
    logic [63:0] m, d, sq;
    m = xv[31] ? {32'd0, ~xv + 32'd1} : {32'd0, xv};
    m = m >> s;
    d = 64'h1_0000 + m;
    if (d >= 64'h100_0000) sq = 64'hFFFF_FFFF;
    else sq = (d * d) >> 16;
    if (sq > 64'hFFFF_FFFF) sq = 64'hFFFF_FFFF;
    return 32'((64'h1_0000_0000) / sq);
  endfunction

  task automatic run_op(input logic [31:0] xv, input logic [31:0] ey,
                        input logic [31:0] ey2, input bit c2);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    x = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_acc", 32'(busy), 32'd1);
    while (!end_signal && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'd34);
    chk("y", y, ey);
    if (c2) chk("y_slope2", y2, ey2);
    chk("busy_end", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("end_pulse", 32'(end_signal), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] rx;
    int first, second, ends, n;
    logic [31:0] ya, yb;

    reset = 1'b1;
    start = 1'b0;
    x = '0;
    #12;
    chk("rst_y", y, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_end", 32'(end_signal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'h0000_0000, 32'h0001_0000, 32'h0, 1'b0);
    run_op(32'h0001_0000, 32'h0000_4000, 32'h0, 1'b0);
    run_op(32'hFFFF_0000, 32'h0000_4000, 32'h0, 1'b0);
    run_op(32'h0003_0000, 32'h0000_1000, 32'h0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);
    run_op(32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1);
    run_op(32'h0004_0000, 32'h0000_0A3D, 32'h0000_4000, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rx = 32'($urandom_range(0, 32'h7_FFFF));
      if ($urandom_range(0, 1) == 1) rx = ~rx + 32'd1;
      run_op(rx, ref_y(rx, 0), ref_y(rx, 2), 1'b1);
    end

    // start held high, x changed mid-operation
    first = 0;
    second = 0;
    ends = 0;
    ya = '0;
    yb = '0;
    @(negedge clk);
    start = 1'b1;
    x = 32'h0001_0000;
    for (int e = 0; e <= 72; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) x = 32'h0003_0000;
      if (end_signal) begin
        ends++;
        if (first == 0) begin
          first = e;
          ya = y;
        end else if (second == 0) begin
          second = e;
          yb = y;
        end
      end
    end
    start = 1'b0;
    chk("held_first", 32'(first), 32'd34);
    chk("held_second", 32'(second), 32'd70);
    chk("held_ends", 32'(ends), 32'd2);
    chk("held_ya", ya, 32'h0000_4000);
    chk("held_yb", yb, 32'h0000_1000);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_drain", 32'(busy), 32'd0);

    // async reset part-way through an operation
    @(negedge clk);
    start = 1'b1;
    x = 32'h0003_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_y", y, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_end", 32'(end_signal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ends = 0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      #1;
      if (end_signal) ends++;
    end
    chk("abort_noend", 32'(ends), 32'd0);
    run_op(32'h0001_0000, 32'h0000_4000, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
